// File: rtl/mm_bus_arb_if.sv
// Bundle of the CPU port, DMA port and shared external bus seen by mm_bus_arb.
// The slave modport is the arbiter's view; the master modport is the requesters' and bus model's view.
interface mm_bus_arb_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;

  logic        dma_req;
  logic        dma_we;
  logic [15:0] dma_addr;
  logic [15:0] dma_wdata;
  logic        dma_ack;
  logic [15:0] dma_rdata;

  logic [15:0] bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_re;
  logic        bus_we;
  logic [15:0] bus_rdata;
  logic        bus_rdy;
  logic        bus_to;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_ack, dma_rdata,
    output bus_addr, bus_wdata, bus_re, bus_we, bus_to,
    input  bus_rdata, bus_rdy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_ack, dma_rdata,
    input  bus_addr, bus_wdata, bus_re, bus_we, bus_to,
    output bus_rdata, bus_rdy
  );
endinterface

// File: rtl/mm_bus_arb.sv
// Round-robin arbiter between a CPU and a DMA port onto one external bus,
// with wait-state support and a bus timeout that completes the access with 16'hDEAD.
module mm_bus_arb #(
  parameter logic [3:0] TIMEOUT = 4'd15
) (
  input logic         clk,
  input logic         rst,
  mm_bus_arb_if.slave io
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  state_t      state_q;
  state_t      state_d;
  logic        owner_q;
  logic        last_owner_q;
  logic        we_q;
  logic        to_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] cpu_rdata_q;
  logic [15:0] dma_rdata_q;
  logic [3:0]  wait_cnt_q;
  logic        any_req;
  logic        grant_dma;
  logic        wait_expired;

  // On a tie, the port that did not own the previous access wins.
  assign any_req      = io.cpu_req || io.dma_req;
  assign grant_dma    = io.dma_req && (!io.cpu_req || (last_owner_q == OWN_CPU));
  assign wait_expired = (wait_cnt_q == (TIMEOUT - 4'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = BUSY;
      BUSY:    if (io.bus_rdy || wait_expired) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // addr_q/wdata_q only change on a grant, so they also serve as the held bus values.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_DMA;
      we_q         <= 1'b0;
      to_q         <= 1'b0;
      addr_q       <= 16'h0000;
      wdata_q      <= 16'h0000;
      cpu_rdata_q  <= 16'h0000;
      dma_rdata_q  <= 16'h0000;
      wait_cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q    <= grant_dma;
            we_q       <= grant_dma ? io.dma_we    : io.cpu_we;
            addr_q     <= grant_dma ? io.dma_addr  : io.cpu_addr;
            wdata_q    <= grant_dma ? io.dma_wdata : io.cpu_wdata;
            wait_cnt_q <= 4'd0;
            to_q       <= 1'b0;
          end
        end
        BUSY: begin
          if (io.bus_rdy) begin
            if (!we_q && (owner_q == OWN_CPU)) cpu_rdata_q <= io.bus_rdata;
            if (!we_q && (owner_q == OWN_DMA)) dma_rdata_q <= io.bus_rdata;
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
            if (wait_expired) begin
              to_q <= 1'b1;
              if (!we_q && (owner_q == OWN_CPU)) cpu_rdata_q <= 16'hDEAD;
              if (!we_q && (owner_q == OWN_DMA)) dma_rdata_q <= 16'hDEAD;
            end
          end
        end
        RESP: begin
          last_owner_q <= owner_q;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    io.bus_re  = 1'b0;
    io.bus_we  = 1'b0;
    io.cpu_ack = 1'b0;
    io.dma_ack = 1'b0;
    io.bus_to  = 1'b0;
    case (state_q)
      BUSY: begin
        io.bus_re = !we_q;
        io.bus_we = we_q;
      end
      RESP: begin
        io.cpu_ack = (owner_q == OWN_CPU);
        io.dma_ack = (owner_q == OWN_DMA);
        io.bus_to  = to_q;
      end
      default: begin
      end
    endcase
  end

  assign io.bus_addr  = addr_q;
  assign io.bus_wdata = wdata_q;
  assign io.cpu_rdata = cpu_rdata_q;
  assign io.dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mm_bus_arb.sv
// Self-checking bench for mm_bus_arb: a per-cycle vector table plus hand-written
// sequences for mid-access reset and round-robin ties straight after reset.
module tb_mm_bus_arb;

  localparam logic L  = 1'b0;
  localparam logic H  = 1'b1;
  localparam int   NV = 29;

  // One row = inputs held for one cycle and the outputs expected in that same cycle.
  typedef struct {
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        dma_req;
    logic        dma_we;
    logic [15:0] dma_addr;
    logic [15:0] dma_wdata;
    logic        bus_rdy;
    logic [15:0] bus_rdata;
    logic        e_re;
    logic        e_we;
    logic [15:0] e_addr;
    logic [15:0] e_wdata;
    logic        e_cack;
    logic        e_dack;
    logic        e_to;
    logic [15:0] e_crd;
    logic [15:0] e_drd;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fails  = 0;
  vec_t vecs [NV];

  mm_bus_arb_if arb_if ();

  mm_bus_arb #(.TIMEOUT(4'd4)) dut (
    .clk (clk),
    .rst (rst),
    .io  (arb_if)
  );

  always #5 clk = ~clk;

  task automatic cmp1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic cmp16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t zeroVec();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst              = v.rst;
    arb_if.cpu_req   = v.cpu_req;
    arb_if.cpu_we    = v.cpu_we;
    arb_if.cpu_addr  = v.cpu_addr;
    arb_if.cpu_wdata = v.cpu_wdata;
    arb_if.dma_req   = v.dma_req;
    arb_if.dma_we    = v.dma_we;
    arb_if.dma_addr  = v.dma_addr;
    arb_if.dma_wdata = v.dma_wdata;
    arb_if.bus_rdy   = v.bus_rdy;
    arb_if.bus_rdata = v.bus_rdata;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    cmp1 ({tag, " bus_re"},    arb_if.bus_re,    v.e_re);
    cmp1 ({tag, " bus_we"},    arb_if.bus_we,    v.e_we);
    cmp16({tag, " bus_addr"},  arb_if.bus_addr,  v.e_addr);
    cmp16({tag, " bus_wdata"}, arb_if.bus_wdata, v.e_wdata);
    cmp1 ({tag, " cpu_ack"},   arb_if.cpu_ack,   v.e_cack);
    cmp1 ({tag, " dma_ack"},   arb_if.dma_ack,   v.e_dack);
    cmp1 ({tag, " bus_to"},    arb_if.bus_to,    v.e_to);
    cmp16({tag, " cpu_rdata"}, arb_if.cpu_rdata, v.e_crd);
    cmp16({tag, " dma_rdata"}, arb_if.dma_rdata, v.e_drd);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    vec_t rv;

    //            rst  cpu req/we/addr/wdata       dma req/we/addr/wdata       rdy/rdata     exp re/we/addr/wdata       cack/dack/to/crd/drd
    // CPU read alone, one BUSY cycle
    vecs[0]  = '{L, H,L,16'h2004,16'h0000, L,L,16'h0000,16'h0000, L,16'h0000, L,L,16'h0000,16'h0000, L,L,L,16'h0000,16'h0000};
    vecs[1]  = '{L, H,L,16'h2004,16'h0000, L,L,16'h0000,16'h0000, H,16'h1234, H,L,16'h2004,16'h0000, L,L,L,16'h0000,16'h0000};
    vecs[2]  = '{L, H,L,16'h2004,16'h0000, L,L,16'h0000,16'h0000, L,16'h0000, L,L,16'h2004,16'h0000, H,L,L,16'h1234,16'h0000};
    vecs[3]  = '{L, L,L,16'h0000,16'h0000, L,L,16'h0000,16'h0000, H,16'h7777, L,L,16'h2004,16'h0000, L,L,L,16'h1234,16'h0000};
    // CPU write keeps cpu_rdata
    vecs[4]  = '{L, H,H,16'hE000,16'h00FF, L,L,16'h0000,16'h0000, L,16'h0000, L,L,16'h2004,16'h0000, L,L,L,16'h1234,16'h0000};
    vecs[5]  = '{L, H,H,16'hE000,16'h00FF, L,L,16'h0000,16'h0000, H,16'h5555, L,H,16'hE000,16'h00FF, L,L,L,16'h1234,16'h0000};
    vecs[6]  = '{L, H,H,16'hE000,16'h00FF, L,L,16'h0000,16'h0000, L,16'h0000, L,L,16'hE000,16'h00FF, H,L,L,16'h1234,16'h0000};
    vecs[7]  = '{L, L,L,16'h0000,16'h0000, L,L,16'h0000,16'h0000, L,16'h0000, L,L,16'hE000,16'h00FF, L,L,L,16'h1234,16'h0000};
    // DMA read with three wait states; rdy arrives just as the counter hits TIMEOUT-1
    vecs[8]  = '{L, L,L,16'h0000,16'h0000, H,L,16'h3000,16'h0000, L,16'h0000, L,L,16'hE000,16'h00FF, L,L,L,16'h1234,16'h0000};
    vecs[9]  = '{L, L,L,16'h0000,16'h0000, H,L,16'h3000,16'h0000, L,16'h0000, H,L,16'h3000,16'h0000, L,L,L,16'h1234,16'h0000};
    vecs[10] = '{L, L,L,16'h0000,16'h0000, H,L,16'h3000,16'h0000, L,16'h0000, H,L,16'h3000,16'h0000, L,L,L,16'h1234,16'h0000};
    vecs[11] = '{L, L,L,16'h0000,16'h0000, H,L,16'h3000,16'h0000, L,16'h0000, H,L,16'h3000,16'h0000, L,L,L,16'h1234,16'h0000};
    vecs[12] = '{L, L,L,16'h0000,16'h0000, H,L,16'h3000,16'h0000, H,16'hABCD, H,L,16'h3000,16'h0000, L,L,L,16'h1234,16'h0000};
    vecs[13] = '{L, L,L,16'h0000,16'h0000, H,L,16'h3000,16'h0000, L,16'h0000, L,L,16'h3000,16'h0000, L,H,L,16'h1234,16'hABCD};
    vecs[14] = '{L, L,L,16'h0000,16'h0000, L,L,16'h0000,16'h0000, L,16'h0000, L,L,16'h3000,16'h0000, L,L,L,16'h1234,16'hABCD};
    // CPU read timing out after four BUSY cycles
    vecs[15] = '{L, H,L,16'h4000,16'h0000, L,L,16'h0000,16'h0000, L,16'h9999, L,L,16'h3000,16'h0000, L,L,L,16'h1234,16'hABCD};
    vecs[16] = '{L, H,L,16'h4000,16'h0000, L,L,16'h0000,16'h0000, L,16'h9999, H,L,16'h4000,16'h0000, L,L,L,16'h1234,16'hABCD};
    vecs[17] = '{L, H,L,16'h4000,16'h0000, L,L,16'h0000,16'h0000, L,16'h9999, H,L,16'h4000,16'h0000, L,L,L,16'h1234,16'hABCD};
    vecs[18] = '{L, H,L,16'h4000,16'h0000, L,L,16'h0000,16'h0000, L,16'h9999, H,L,16'h4000,16'h0000, L,L,L,16'h1234,16'hABCD};
    vecs[19] = '{L, H,L,16'h4000,16'h0000, L,L,16'h0000,16'h0000, L,16'h9999, H,L,16'h4000,16'h0000, L,L,L,16'h1234,16'hABCD};
    vecs[20] = '{L, H,L,16'h4000,16'h0000, L,L,16'h0000,16'h0000, L,16'h0000, L,L,16'h4000,16'h0000, H,L,H,16'hDEAD,16'hABCD};
    vecs[21] = '{L, L,L,16'h0000,16'h0000, L,L,16'h0000,16'h0000, L,16'h0000, L,L,16'h4000,16'h0000, L,L,L,16'hDEAD,16'hABCD};
    // Tie with last owner CPU: DMA wins, CPU follows after one IDLE cycle
    vecs[22] = '{L, H,H,16'h5000,16'h1111, H,H,16'h6000,16'h2222, L,16'h0000, L,L,16'h4000,16'h0000, L,L,L,16'hDEAD,16'hABCD};
    vecs[23] = '{L, H,H,16'h5000,16'h1111, H,H,16'h6000,16'h2222, H,16'h0000, L,H,16'h6000,16'h2222, L,L,L,16'hDEAD,16'hABCD};
    vecs[24] = '{L, H,H,16'h5000,16'h1111, H,H,16'h6000,16'h2222, L,16'h0000, L,L,16'h6000,16'h2222, L,H,L,16'hDEAD,16'hABCD};
    vecs[25] = '{L, H,H,16'h5000,16'h1111, L,L,16'h0000,16'h0000, L,16'h0000, L,L,16'h6000,16'h2222, L,L,L,16'hDEAD,16'hABCD};
    vecs[26] = '{L, H,H,16'h5000,16'h1111, L,L,16'h0000,16'h0000, H,16'h0000, L,H,16'h5000,16'h1111, L,L,L,16'hDEAD,16'hABCD};
    vecs[27] = '{L, H,H,16'h5000,16'h1111, L,L,16'h0000,16'h0000, L,16'h0000, L,L,16'h5000,16'h1111, H,L,L,16'hDEAD,16'hABCD};
    vecs[28] = '{L, L,L,16'h0000,16'h0000, L,L,16'h0000,16'h0000, L,16'h0000, L,L,16'h5000,16'h1111, L,L,L,16'hDEAD,16'hABCD};

    // Reset values; rv carries the reset-state expectations
    v = zeroVec();
    v.rst = H;
    applyStimulus(v);
    repeat (2) step();
    rv = zeroVec();
    checkOutput("reset", rv);
    v.rst = L;
    applyStimulus(v);

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("row%0d", i), vecs[i]);
      step();
    end

    // Reset during the second BUSY cycle aborts with no ack
    v = zeroVec();
    v.cpu_req  = H;
    v.cpu_addr = 16'h7000;
    applyStimulus(v);
    step();
    cmp1("midrst busy1 bus_re", arb_if.bus_re, H);
    step();
    cmp16("midrst busy2 bus_addr", arb_if.bus_addr, 16'h7000);
    v.rst = H;
    applyStimulus(v);
    step();
    v = zeroVec();
    applyStimulus(v);
    checkOutput("midrst after", rv);
    step();
    cmp1("midrst no late ack", arb_if.cpu_ack, L);
    cmp1("midrst idle bus_re", arb_if.bus_re, L);

    // Ties after reset: CPU, then DMA, then CPU again
    v = zeroVec();
    v.cpu_req = H; v.cpu_we = H; v.cpu_addr = 16'h8000; v.cpu_wdata = 16'hAAAA;
    v.dma_req = H; v.dma_we = H; v.dma_addr = 16'h9000; v.dma_wdata = 16'hBBBB;
    applyStimulus(v);
    step();
    v.bus_rdy = H;
    applyStimulus(v);
    cmp16("tie1 bus_addr", arb_if.bus_addr, 16'h8000);
    cmp1 ("tie1 bus_we", arb_if.bus_we, H);
    step();
    cmp1("tie1 cpu_ack", arb_if.cpu_ack, H);
    cmp1("tie1 dma_ack", arb_if.dma_ack, L);
    step();
    v.cpu_req = L;
    applyStimulus(v);
    cmp1("tie2 idle dma_ack", arb_if.dma_ack, L);
    step();
    cmp16("tie2 bus_addr", arb_if.bus_addr, 16'h9000);
    cmp16("tie2 bus_wdata", arb_if.bus_wdata, 16'hBBBB);
    step();
    cmp1("tie2 dma_ack", arb_if.dma_ack, H);
    cmp1("tie2 cpu_ack", arb_if.cpu_ack, L);
    step();
    v.cpu_req = H; v.cpu_addr = 16'h8004; v.cpu_wdata = 16'hCCCC;
    applyStimulus(v);
    step();
    cmp16("tie3 bus_addr", arb_if.bus_addr, 16'h8004);
    cmp16("tie3 bus_wdata", arb_if.bus_wdata, 16'hCCCC);
    step();
    cmp1("tie3 cpu_ack", arb_if.cpu_ack, H);
    cmp1("tie3 dma_ack", arb_if.dma_ack, L);
    v = zeroVec();
    applyStimulus(v);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mm_bus_arb.md
MM_BUS_ARB -- requirements
Module: mm_bus_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 4'd15, meaning the number of BUSY cycles without bus_rdy after which an access is aborted (legal values 1..15).
REQ-002 SHALL have clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have cpu_req  input  1  CPU access request, held until cpu_ack.
REQ-005 SHALL have cpu_we, cpu_addr, cpu_wdata  input  1/16/16  CPU write flag (0 = read), address and write data.
REQ-006 SHALL have cpu_ack, cpu_rdata  output  1/16  one-cycle completion pulse and registered read data.
REQ-007 SHALL have dma_req, dma_we, dma_addr, dma_wdata  input  1/1/16/16  DMA request port, same semantics as the CPU port.
REQ-008 SHALL have dma_ack, dma_rdata  output  1/16  DMA completion pulse and registered read data.
REQ-009 SHALL have bus_addr, bus_wdata  output  16/16  shared external bus address and write data.
REQ-010 SHALL have bus_re, bus_we  output  1/1  external read and write strobes.
REQ-011 SHALL have bus_rdata, bus_rdy  input  16/1  external read data and completion indication.
REQ-012 SHALL have bus_to  output  1  timeout pulse, asserted together with the owner's ack.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, BUSY, RESP.
REQ-014 In IDLE with any req high, SHALL latch owner, we, addr and wdata from the winning port, clear the wait counter, and enter BUSY.
REQ-015 Arbitration SHALL be as follows: a single requester wins; if both request, the port that was not last_owner wins (round-robin).
REQ-016 In BUSY, SHALL drive bus_addr and bus_wdata from the latched registers, with bus_re = ~we_q and bus_we = we_q.
REQ-017 In every state other than BUSY, bus_re and bus_we SHALL be 0, and bus_addr and bus_wdata SHALL hold their last values.
REQ-018 In BUSY, when bus_rdy = 1 the FSM SHALL enter RESP. On a read, bus_rdata SHALL be captured into the owner's rdata register.
REQ-019 In BUSY, when bus_rdy = 0 the 4-bit wait counter SHALL increment. When the counter equals TIMEOUT-1 with bus_rdy still 0, the FSM SHALL enter RESP with the timeout flag set. On a timed-out read, the owner's rdata SHALL be loaded with 16'hDEAD.
REQ-020 In RESP, SHALL pulse the owner's ack for exactly one cycle, pulse bus_to if the timeout flag is set, update last_owner to the owner, and return to IDLE.
REQ-021 Latency: with req sampled in IDLE at cycle T and bus_rdy = 1 in the first BUSY cycle (T+1), ack SHALL be high in cycle T+2. Each additional wait cycle SHALL add one cycle.
REQ-022 A requester SHALL deassert req on the edge where its ack is high. A req still high in the following IDLE cycle SHALL be treated as a new request.
REQ-023 Writes SHALL NOT modify cpu_rdata or dma_rdata. Each rdata register SHALL hold its value until the next completed read by that owner.
REQ-024 The non-owner port's ack SHALL remain 0 throughout an access, and its req and inputs SHALL be ignored until IDLE.
REQ-025 bus_rdy SHALL be ignored outside BUSY.
REQ-026 A new grant SHALL occur only from IDLE, so back-to-back accesses are separated by at least one IDLE cycle.

Reset
REQ-027 When rst = 1 at an edge, SHALL set: state = IDLE; cpu_ack = dma_ack = bus_to = 0; bus_re = bus_we = 0; bus_addr = bus_wdata = 0; cpu_rdata = dma_rdata = 0; wait counter = 0; last_owner = DMA (so the CPU wins the first tie).
REQ-028 Reset asserted during BUSY or RESP SHALL abort the access with no ack issued, and the strobes SHALL be 0 in the cycle after the reset edge.

Verification
REQ-029 CPU read alone: cpu_req = 1, cpu_we = 0, cpu_addr = 16'h2004, bus_rdy = 1 in the first BUSY cycle with bus_rdata = 16'h1234 -> bus_re = 1 for one cycle with bus_addr = 16'h2004; cpu_ack high 2 cycles after the request is sampled; cpu_rdata = 16'h1234.
REQ-030 Simultaneous requests after reset: CPU and DMA both request writes -> CPU granted first. DMA is granted in the IDLE cycle following cpu_ack. With both requesting again, the CPU wins again (last_owner = DMA).
REQ-031 Wait states: DMA read with bus_rdy delayed 3 cycles -> bus_re held for 4 cycles; dma_ack at T+5; bus_to = 0.
REQ-032 Timeout: TIMEOUT = 4, CPU read with bus_rdy held 0 -> 4 BUSY cycles, then cpu_ack = bus_to = 1 for one cycle and cpu_rdata = 16'hDEAD.
REQ-033 Write preserves read data: CPU write of 16'h00FF to 16'hE000 after a prior read of 16'h1234 -> bus_we = 1, bus_wdata = 16'h00FF, cpu_rdata stays 16'h1234.
REQ-034 Mid-access reset: rst = 1 in the second BUSY cycle -> strobes 0 in the next cycle, no ack pulse, all outputs at their REQ-027 reset values.
